// File: rtl/enigma_session_ctrl.sv
// Two-channel message scheduler for a shared three-rotor Enigma core.
// Re-keys the rotors per message, streams symbols in, drains returns out.
module enigma_session_ctrl #(
  parameter int LATENCY = 6,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i,
  input  logic [1:0]       sym_val_i,
  input  logic [1:0][6:0]  sym_i,
  input  logic [1:0]       last_i,
  output logic [1:0]       sym_rdy_o,
  output logic [1:0]       grant_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] sym_cnt_o,
  output logic             core_rrs_rst_o,
  output logic             core_en_val_o,
  output logic [6:0]       core_symb_o,
  input  logic             core_val_i,
  input  logic [6:0]       core_symb_i,
  output logic [1:0]       out_val_o,
  output logic [6:0]       out_symb_o
);

  localparam int OW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE,
    ROTRST,
    STREAM,
    DRAIN
  } state_t;

  state_t        state;
  logic          rr;
  logic [OW-1:0] outs;
  logic [OW-1:0] outs_nxt;
  logic          g;
  logic [6:0]    sym_g;
  logic          hs;
  logic          sym_ok;
  logic          fwd;
  logic          ret;
  logic          pick;

  assign g         = grant_o[1];
  assign sym_g     = sym_i[g];
  assign sym_rdy_o = (state == STREAM) ? grant_o : 2'b00;
  assign busy_o    = (state != IDLE);
  assign hs        = |(sym_val_i & sym_rdy_o);
  assign sym_ok    = (sym_g >= 7'd1) && (sym_g <= 7'd26);
  assign fwd       = hs & sym_ok;
  // returns with nothing in flight are strays and are ignored
  assign ret       = core_val_i & (outs != '0);
  assign outs_nxt  = outs + OW'(fwd) - OW'(ret);
  assign pick      = (&req_i) ? rr : req_i[1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      rr             <= 1'b0;
      outs           <= '0;
      grant_o        <= 2'b00;
      err_o          <= 1'b0;
      sym_cnt_o      <= '0;
      core_rrs_rst_o <= 1'b1;
      core_en_val_o  <= 1'b0;
      core_symb_o    <= '0;
      out_val_o      <= 2'b00;
      out_symb_o     <= '0;
    end else begin
      core_rrs_rst_o <= 1'b1;
      core_en_val_o  <= fwd;
      err_o          <= hs & ~sym_ok;
      outs           <= outs_nxt;
      out_val_o      <= ret ? grant_o : 2'b00;
      out_symb_o     <= core_symb_i;
      if (fwd) begin
        core_symb_o <= sym_g;
      end
      if (fwd && (sym_cnt_o != '1)) begin
        sym_cnt_o <= sym_cnt_o + CNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (|req_i) begin
            grant_o        <= pick ? 2'b10 : 2'b01;
            rr             <= ~pick;
            core_rrs_rst_o <= 1'b0;
            sym_cnt_o      <= '0;
            state          <= ROTRST;
          end
        end
        ROTRST: begin
          state <= STREAM;
        end
        STREAM: begin
          if (hs && last_i[g]) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // last return lands this cycle: go idle together with it
          if ((outs_nxt == '0) && !core_en_val_o) begin
            state   <= IDLE;
            grant_o <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/enigma_session_ctrl.md
# enigma_session_ctrl

Message-level scheduler that shares one three-rotor Enigma encoder core between two requesting channels. It grants the core to one channel per message, re-keys the rotors with a one-cycle rotor-reset pulse before each message, and streams the message's symbols into the core. It routes the encoded symbols back to the owning channel and drains the core pipeline completely before the next message may start.

## Interface
Parameters:
- LATENCY, 6, core cycles from `core_en_val_o` high to `core_val_i` high.
- CNT_W, 8, width of the per-message symbol counter.

Ports:
- clk_i  in  1  synchrosignal; all logic on posedge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  2  per-channel message request, level; held until the message's last symbol is accepted.
- sym_val_i  in  2  per-channel symbol valid.
- sym_i  in  2x7  per-channel plaintext symbol, letter serial number 1..26.
- last_i  in  2  per-channel marks the final symbol of a message; qualified by handshake.
- sym_rdy_o  out  2  per-channel ready.
- grant_o  out  2  one-hot owner of the core; 0 when idle.
- busy_o  out  1  high in any state except IDLE.
- err_o  out  1  one-cycle pulse when an out-of-range symbol is dropped.
- sym_cnt_o  out  CNT_W  number of symbols forwarded in the current message; saturates.
- core_rrs_rst_o  out  1  core rotor reset, active-low.
- core_en_val_o  out  1  core symbol valid.
- core_symb_o  out  7  symbol to core.
- core_val_i  in  1  core encoded-valid.
- core_symb_i  in  7  core encoded symbol.
- out_val_o  out  2  per-channel encoded-symbol valid.
- out_symb_o  out  7  encoded symbol, shared by both channels.

## Operation
FSM states: IDLE, ROTRST, STREAM, DRAIN.

- **IDLE**
  - If no request is present, stay in IDLE.
  - If only one channel requests, grant that channel.
  - If both channels request, grant the channel at round-robin pointer `rr` (reset to 0).
  - On a grant: `grant_o` is set and the FSM goes to ROTRST.
  - `rr` becomes the channel that was not just granted.
- **ROTRST**
  - `core_rrs_rst_o` is 0 for exactly this one cycle.
  - `sym_cnt_o` clears to 0.
  - Next state is STREAM.
- **STREAM**
  - `sym_rdy_o[g]` = 1 for the granted channel g; the other channel's ready is 0.
  - A handshake is `sym_val_i[g] & sym_rdy_o[g]`.
  - For a handshake with a symbol in 1..26:
    - register the symbol onto `core_symb_o`;
    - pulse `core_en_val_o` the next cycle;
    - increment the outstanding counter `outs` and `sym_cnt_o`.
  - For a handshake with symbol 0 or 27..127:
    - the symbol is consumed and not forwarded;
    - `err_o` pulses the next cycle;
    - the counters are unchanged.
  - A handshake with `last_i[g]` = 1, valid or dropped symbol, moves the FSM to DRAIN.
- **DRAIN**
  - `sym_rdy_o` = 0.
  - Leave for IDLE when `outs` == 0 and `core_en_val_o` == 0; `grant_o` clears on that transition.
- **Outstanding counter** `outs`
  - Width is clog2(LATENCY+2).
  - It increments on a forwarded symbol and decrements on `core_val_i`; if both happen in the same cycle it is unchanged.
  - `core_val_i` while `outs` == 0 is ignored: no underflow, no output.
- **Return path**
  - `out_val_o[g]` <= `core_val_i`; `out_symb_o` <= `core_symb_i`.
  - g is the grant held in that cycle. The grant cannot change before the last return, because DRAIN waits for `outs` == 0.
- `sym_cnt_o` saturates at 2^CNT_W−1.
- Deasserting `req_i` mid-message has no effect; only `last_i` ends a message.
- Reset mid-operation forces IDLE immediately. The pipeline contents are abandoned, and the core is re-keyed on the next grant.

## Timing
- Reset values:
  - `sym_rdy_o`=0, `grant_o`=0, `busy_o`=0, `err_o`=0, `sym_cnt_o`=0.
  - `core_rrs_rst_o`=1, `core_en_val_o`=0, `core_symb_o`=0.
  - `out_val_o`=0, `out_symb_o`=0.
  - `rr`=0, `outs`=0.
- All outputs are registered. `sym_rdy_o` is decoded from registered state.
- Request sampled in IDLE at cycle t:
  - ROTRST in cycle t+1, with `core_rrs_rst_o` low during t+1;
  - STREAM from t+2, with the first ready in t+2.
- Handshake in cycle h:
  - `core_en_val_o` in h+1;
  - `core_val_i` in h+1+LATENCY;
  - `out_val_o` in h+2+LATENCY, which is h+8 at default LATENCY.
- Sustained throughput is 1 symbol/cycle.
- Per-message overhead: 2 cycles before the first ready, plus drain.
- Last handshake in cycle h:
  - IDLE in cycle h+LATENCY+2;
  - the final `out_val_o` appears in the same cycle h+LATENCY+2;
  - a new grant is possible at h+LATENCY+3.

## Test plan
- **Reset:** hold `rst_i`=0 → every output at its reset value. Release, no requests → `busy_o` stays 0 for 20 cycles.
- **Single message:** channel 0 sends 1,2,3 (last on 3), `sym_val_i` continuously high → one `core_rrs_rst_o` low pulse; `core_en_val_o` high for 3 consecutive cycles carrying 1,2,3; `out_val_o[0]` for 3 cycles, first at first handshake+8; `sym_cnt_o`=3; back in IDLE at last handshake+8.
- **Arbitration:** both `req_i` high from reset → channel 0 served first, then channel 1. Channel 0 re-requests during channel 1's message → channel 0 granted next, each grant with a fresh rotor-reset pulse. `out_val_o[1]` is never high during channel 0's returns.
- **Invalid symbols:** channel 1 sends 0,5,27 (last on 27) → `err_o` pulses twice; only 5 is forwarded; `sym_cnt_o`=1; DRAIN entered on the 27.
- **Bubbles:** channel 0 sends 4 symbols with `sym_val_i` toggled every cycle → 4 returns in order, `outs` reaches 0 only after the 4th `core_val_i`, and grant is held throughout.
- **Mid-stream reset and late message:** `rst_i` pulsed low during DRAIN → immediate IDLE with `out_val_o`=0. The next request gets a rotor-reset pulse. A stray `core_val_i` while `outs`=0 produces no `out_val_o`.
